// File: rtl/mac_seq_ctrl.sv
`timescale 1ns/1ps
// mac_seq_ctrl: control FSM that sequences a shift-add multiply-accumulate
// datapath over a programmable number of operand pairs.
module mac_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pairs,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mult_lsb,
    output logic             ld_operands,
    output logic             shift_en,
    output logic             add_en,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             busy,
    output logic             done
);

    localparam int               BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_WAIT_IN = 3'd2,
        S_MULT    = 3'd3,
        S_ACCUM   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_n_reg;
    logic [CNT_W-1:0] r_pair_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             w_last_bit;
    logic             w_last_pair;

    assign w_last_bit  = (r_bit_cnt == BIT_LAST);
    // Only evaluated in ACCUM, where n_reg is known to be at least 1.
    assign w_last_pair = (r_pair_cnt == (r_n_reg - CNT_ONE));

    // NOTE: flops use non-blocking assignment so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_n_reg    <= '0;
            r_pair_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n_reg <= num_pairs;
                    end
                end
                S_INIT: begin
                    r_pair_cnt <= '0;
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        r_bit_cnt <= '0;
                    end
                end
                S_MULT: begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                S_ACCUM: begin
                    r_pair_cnt <= r_pair_cnt + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: every output and the next state get a default before the case,
    // so no path through this block can infer a latch.
    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        ld_operands = 1'b0;
        shift_en    = 1'b0;
        add_en      = 1'b0;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                acc_clr = 1'b1;
                busy    = 1'b1;
                w_next  = (r_n_reg == '0) ? S_DONE : S_WAIT_IN;
            end
            S_WAIT_IN: begin
                in_ready    = 1'b1;
                busy        = 1'b1;
                ld_operands = in_valid;
                if (in_valid) begin
                    w_next = S_MULT;
                end
            end
            S_MULT: begin
                shift_en = 1'b1;
                add_en   = mult_lsb;
                busy     = 1'b1;
                if (w_last_bit) begin
                    w_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_en = 1'b1;
                busy   = 1'b1;
                w_next = w_last_pair ? S_DONE : S_WAIT_IN;
            end
            S_DONE: begin
                done   = 1'b1;
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
`timescale 1ns/1ps
// tb_mac_seq_ctrl: builds the expected per-cycle output schedule of each job
// from its pair count and stall plan, then compares the DUT every cycle.
module tb_mac_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic in_ready;
        logic ld;
        logic shift;
        logic add;
        logic acc_clr;
        logic acc_en;
        logic busy;
        logic done;
    } out_t;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic [CNT_W-1:0] num_pairs;
    logic             in_valid;
    logic             mult_lsb;
    logic             in_ready;
    logic             ld_operands;
    logic             shift_en;
    logic             add_en;
    logic             acc_clr;
    logic             acc_en;
    logic             busy;
    logic             done;

    out_t       act;
    out_t       exp_out;
    bit         check_en;
    int         cyc;
    int         total = 0;
    int         bad = 0;
    int         n_ld = 0;
    int         n_shift = 0;
    int         n_acc = 0;
    int         n_done = 0;
    int         last_done_cyc = -1;
    int         last_acc_cyc = -1;
    logic [7:0] add_bits = '0;
    int         stall_plan[16];

    always #5 clk = ~clk;

    assign act = {in_ready, ld_operands, shift_en, add_en, acc_clr, acc_en, busy, done};

    mac_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .num_pairs   (num_pairs),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mult_lsb    (mult_lsb),
        .ld_operands (ld_operands),
        .shift_en    (shift_en),
        .add_en      (add_en),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // Single compare process: outputs are sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            check($sformatf("outs_cyc%0d", cyc), 32'(act), 32'(exp_out));
            if (act.ld)     n_ld++;
            if (act.shift)  n_shift++;
            if (act.acc_en) begin n_acc++; last_acc_cyc = cyc; end
            if (act.done)   begin n_done++; last_done_cyc = cyc; end
            if (act.shift)  add_bits = {add_bits[6:0], act.add};
        end
    end

    // Runs one job of n pairs. pat_mode drives mult_lsb with 1,0,1,1,0,0,0,1
    // in MULT and 1 everywhere else; abort_at>0 asserts clr in that cycle.
    task automatic run_job(input int n, input int abort_at, input bit pat_mode);
        out_t       eq[$];
        bit         vq[$];
        bit         lq[$];
        out_t       e;
        bit         l;
        logic [7:0] pat;
        int         len;
        pat = 8'b1011_0001;

        e = '0; e.acc_clr = 1'b1; e.busy = 1'b1;
        eq.push_back(e); vq.push_back(rb()); lq.push_back(pat_mode ? 1'b1 : rb());
        for (int p = 0; p < n; p++) begin
            for (int s = 0; s < stall_plan[p]; s++) begin
                e = '0; e.in_ready = 1'b1; e.busy = 1'b1;
                eq.push_back(e); vq.push_back(1'b0); lq.push_back(pat_mode ? 1'b1 : rb());
            end
            e = '0; e.in_ready = 1'b1; e.ld = 1'b1; e.busy = 1'b1;
            eq.push_back(e); vq.push_back(1'b1); lq.push_back(pat_mode ? 1'b1 : rb());
            for (int b = 0; b < WIDTH; b++) begin
                l = pat_mode ? pat[7-b] : rb();
                e = '0; e.shift = 1'b1; e.add = l; e.busy = 1'b1;
                eq.push_back(e); vq.push_back(rb()); lq.push_back(l);
            end
            e = '0; e.acc_en = 1'b1; e.busy = 1'b1;
            eq.push_back(e); vq.push_back(rb()); lq.push_back(pat_mode ? 1'b1 : rb());
        end
        e = '0; e.done = 1'b1; e.busy = 1'b1;
        eq.push_back(e); vq.push_back(rb()); lq.push_back(pat_mode ? 1'b1 : rb());
        e = '0;
        eq.push_back(e); vq.push_back(rb()); lq.push_back(pat_mode ? 1'b1 : rb());
        len = eq.size();

        @(posedge clk); #1;
        start     = 1'b1;
        num_pairs = CNT_W'(n);
        in_valid  = rb();
        mult_lsb  = pat_mode ? 1'b1 : rb();
        cyc       = 0;
        exp_out   = '0;
        check_en  = 1'b1;

        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            cyc       = c;
            exp_out   = eq[c-1];
            in_valid  = vq[c-1];
            mult_lsb  = lq[c-1];
            start     = (c == len) ? 1'b0 : rb();
            num_pairs = CNT_W'($urandom);
            if (c == abort_at) begin
                @(negedge clk); #2;
                check_en = 1'b0;
                clr      = 1'b1;
                #1 check("clr_async", 32'(act), 32'h0);
                @(posedge clk); #1;
                check("clr_hold", 32'(act), 32'h0);
                @(negedge clk); #2;
                start = 1'b0;
                clr   = 1'b0;
                #1 check("clr_release", 32'(act), 32'h0);
                exp_out  = '0;
                cyc      = -1;
                check_en = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = rb();
            mult_lsb = rb();
            exp_out  = '0;
            cyc      = -1;
            check_en = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ld0, sh0, ac0, dn0, n;
        clr = 1'b1; start = 1'b0; in_valid = 1'b0; mult_lsb = 1'b0;
        num_pairs = '0; check_en = 1'b0; exp_out = '0; cyc = -1;
        foreach (stall_plan[i]) stall_plan[i] = 0;

        #3 check("reset_async", 32'(act), 32'h0);
        @(negedge clk); #2 clr = 1'b0;
        idle_cycles(3);

        run_job(1, 0, 1'b0);
        check("single_done_cycle", 32'(last_done_cyc), 32'd12);
        check("single_acc_cycle", 32'(last_acc_cyc), 32'd11);

        stall_plan[1] = 2;
        ld0 = n_ld; sh0 = n_shift; ac0 = n_acc;
        run_job(3, 0, 1'b0);
        stall_plan[1] = 0;
        check("three_ld_count", 32'(n_ld - ld0), 32'd3);
        check("three_shift_count", 32'(n_shift - sh0), 32'd24);
        check("three_acc_count", 32'(n_acc - ac0), 32'd3);
        check("three_done_cycle", 32'(last_done_cyc), 32'd34);

        run_job(1, 0, 1'b1);
        check("add_pattern", 32'(add_bits), 32'hB1);

        ld0 = n_ld; ac0 = n_acc;
        run_job(0, 0, 1'b0);
        check("zero_done_cycle", 32'(last_done_cyc), 32'd2);
        check("zero_ld_count", 32'(n_ld - ld0), 32'd0);
        check("zero_acc_count", 32'(n_acc - ac0), 32'd0);

        dn0 = n_done;
        run_job(3, 6, 1'b0);
        idle_cycles(3);
        check("abort_no_done", 32'(n_done - dn0), 32'd0);
        run_job(1, 0, 1'b0);
        check("post_abort_done_cycle", 32'(last_done_cyc), 32'd12);

        for (int j = 0; j < 8; j++) begin
            n = (j == 7) ? 15 : $urandom_range(6, 0);
            foreach (stall_plan[i]) stall_plan[i] = $urandom_range(3, 0);
            dn0 = n_done;
            run_job(n, 0, 1'b0);
            check("rand_done_pulse", 32'(n_done - dn0), 32'd1);
            if ($urandom_range(1, 0) == 1) idle_cycles($urandom_range(3, 1));
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
